// File: rtl/spi_target.sv
// spi_target: oversampled SPI target (mode 0, or mode 2 via CPOL) with a one-entry TX holding register
module spi_target #(
    parameter logic       CPOL      = 1'b0,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       UNDERRUN
);
    typedef enum logic [1:0] {WAIT_DESEL, IDLE, ACTIVE} state_t;
    state_t      state;
    logic [2:0]  sck_s, nss_s, count;
    logic [1:0]  mosi_s;
    logic [7:0]  sr, hold, ld_byte;
    logic        full, rise, fall, nss_fall, desel, load;
    always_comb begin
        rise     = (sck_s[1] ^ CPOL) & ~(sck_s[2] ^ CPOL);
        fall     = ~(sck_s[1] ^ CPOL) & (sck_s[2] ^ CPOL);
        nss_fall = ~nss_s[1] & nss_s[2];
        desel    = nss_s[1];
        load     = (state == IDLE && nss_fall) || (state == ACTIVE && !desel && rise && count == 3'd7);
        ld_byte  = full ? hold : TX_VALID ? TX_DATA : IDLE_BYTE;
        TX_READY = ~full;
    end
    // nSS stages reset to "selected" so a frame already in progress after reset is never joined
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sck_s    <= {3{CPOL}};
            nss_s    <= '0;
            mosi_s   <= '0;
            sr       <= '0;
            hold     <= '0;
            full     <= 1'b0;
            count    <= '0;
            state    <= WAIT_DESEL;
            MISO     <= 1'b1;
            MISO_OE  <= 1'b0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            sck_s    <= {sck_s[1:0], SCK};
            nss_s    <= {nss_s[1:0], nSS};
            mosi_s   <= {mosi_s[0], MOSI};
            RX_VALID <= 1'b0;
            UNDERRUN <= load && !full && !TX_VALID;
            full     <= load ? 1'b0 : full | TX_VALID;
            if (!full && TX_VALID) hold <= TX_DATA;
            case (state)
                WAIT_DESEL: if (desel) state <= IDLE;
                IDLE: if (nss_fall) begin
                    MISO_OE <= 1'b1;
                    BUSY    <= 1'b1;
                    count   <= '0;
                    state   <= ACTIVE;
                end
                ACTIVE: if (desel) begin
                    MISO_OE <= 1'b0;
                    BUSY    <= 1'b0;
                    count   <= '0;
                    state   <= IDLE;
                end else if (rise) begin
                    sr    <= {sr[6:0], mosi_s[1]};
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        RX_DATA  <= {sr[6:0], mosi_s[1]};
                        RX_VALID <= 1'b1;
                    end
                end else if (fall) MISO <= sr[7];
                default: state <= WAIT_DESEL;
            endcase
            // a load overrides the shift and presents the new MSB immediately
            if (load) begin
                sr   <= ld_byte;
                MISO <= ld_byte[7];
            end
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: table-driven and scoreboard bench for spi_target in mode 0 and mode 2
module tb_spi_target;
    logic       clk = 0, rst = 1, sck = 0, mosi = 0, nss0 = 1, nss1 = 1;
    logic       tx_valid0 = 0, tx_valid1 = 0, sel = 0;
    logic [7:0] tx_data = 0;
    logic       miso0, oe0, rdy0, rxv0, busy0, und0;
    logic       miso1, oe1, rdy1, rxv1, busy1, und1;
    logic [7:0] rxd0, rxd1;
    logic       m_miso, m_oe, m_rdy, m_rxv, m_busy, m_und;
    logic [7:0] m_rxd;
    int         checks = 0, errors = 0, n_rxv = 0, n_und = 0;
    logic [7:0] exp_q[$];

    spi_target #(.CPOL(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .SCK(sck), .MOSI(mosi), .nSS(nss0),
        .MISO(miso0), .MISO_OE(oe0), .TX_DATA(tx_data), .TX_VALID(tx_valid0), .TX_READY(rdy0),
        .RX_DATA(rxd0), .RX_VALID(rxv0), .BUSY(busy0), .UNDERRUN(und0)
    );
    spi_target #(.CPOL(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .SCK(~sck), .MOSI(mosi), .nSS(nss1),
        .MISO(miso1), .MISO_OE(oe1), .TX_DATA(tx_data), .TX_VALID(tx_valid1), .TX_READY(rdy1),
        .RX_DATA(rxd1), .RX_VALID(rxv1), .BUSY(busy1), .UNDERRUN(und1)
    );

    always #5 clk = ~clk;

    assign m_miso = sel ? miso1 : miso0;
    assign m_oe   = sel ? oe1   : oe0;
    assign m_rdy  = sel ? rdy1  : rdy0;
    assign m_rxv  = sel ? rxv1  : rxv0;
    assign m_rxd  = sel ? rxd1  : rxd0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_und  = sel ? und1  : und0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_rxv) begin
            n_rxv++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected none", m_rxd);
            end else chk("rx_data", {24'd0, m_rxd}, {24'd0, exp_q.pop_front()});
        end
        if (m_und) n_und++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_nss(input logic v);
        if (sel) nss1 = v; else nss0 = v;
    endtask

    task automatic write_tx(input logic [7:0] b);
        chk("tx_ready_before_write", {31'd0, m_rdy}, 32'd1);
        tx_data = b;
        if (sel) tx_valid1 = 1; else tx_valid0 = 1;
        wait_clk(1);
        tx_valid0 = 0;
        tx_valid1 = 0;
    endtask

    task automatic bit_cycle(input logic b, input logic check, input logic exp_bit);
        mosi = b;
        wait_clk(8);
        if (check) begin
            chk("miso_bit", {31'd0, m_miso}, {31'd0, exp_bit});
            chk("busy_in_frame", {31'd0, m_busy}, 32'd1);
        end
        sck = 1;
        wait_clk(8);
        sck = 0;
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input logic [7:0] mi, input logic check);
        exp_q.push_back(mo);
        for (int i = 7; i >= 0; i--) bit_cycle(mo[i], check, mi[i]);
        wait_clk(2);
    endtask

    task automatic deselect();
        set_nss(1);
        wait_clk(2);
        chk("busy_before_drop", {31'd0, m_busy}, 32'd1);
        wait_clk(1);
        chk("busy_after_drop", {31'd0, m_busy}, 32'd0);
        chk("oe_after_drop", {31'd0, m_oe}, 32'd0);
        wait_clk(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, {31'd0, m_miso}, 32'd1);
        chk({tag, "_oe"}, {31'd0, m_oe}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, m_rdy}, 32'd1);
        chk({tag, "_rxd"}, {24'd0, m_rxd}, 32'd0);
        chk({tag, "_rxv"}, {31'd0, m_rxv}, 32'd0);
        chk({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        chk({tag, "_und"}, {31'd0, m_und}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] mosi, tx, nxt, exp_miso;
        logic       pre, has_nxt;
        int         und_sel, und_tot;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int r0, u0;
        vecs[0] = '{mosi: 8'hA5, tx: 8'h3C, nxt: 8'h55, exp_miso: 8'h3C, pre: 1, has_nxt: 1, und_sel: 0, und_tot: 0};
        vecs[1] = '{mosi: 8'h00, tx: 8'h00, nxt: 8'h00, exp_miso: 8'hFF, pre: 0, has_nxt: 0, und_sel: 1, und_tot: 2};
        vecs[2] = '{mosi: 8'hC3, tx: 8'h96, nxt: 8'h00, exp_miso: 8'h96, pre: 1, has_nxt: 0, und_sel: 0, und_tot: 1};
        vecs[3] = '{mosi: 8'hFF, tx: 8'h00, nxt: 8'hAA, exp_miso: 8'h00, pre: 1, has_nxt: 1, und_sel: 0, und_tot: 0};

        wait_clk(3);
        check_reset_outputs("reset");
        rst = 0;
        wait_clk(5);

        foreach (vecs[k]) begin
            r0 = n_rxv;
            u0 = n_und;
            if (vecs[k].pre) write_tx(vecs[k].tx);
            set_nss(0);
            wait_clk(6);
            chk("und_at_select", n_und - u0, vecs[k].und_sel);
            chk("oe_at_select", {31'd0, m_oe}, 32'd1);
            if (vecs[k].has_nxt) write_tx(vecs[k].nxt);
            xfer_byte(vecs[k].mosi, vecs[k].exp_miso, 1);
            chk("tx_ready_after_load", {31'd0, m_rdy}, 32'd1);
            deselect();
            chk("rx_pulses", n_rxv - r0, 1);
            chk("und_total", n_und - u0, vecs[k].und_tot);
            chk("queue_drained", exp_q.size(), 0);
        end

        r0 = n_rxv;
        write_tx(8'h81);
        set_nss(0);
        wait_clk(6);
        write_tx(8'h7E);
        xfer_byte(8'h12, 8'h81, 1);
        xfer_byte(8'h34, 8'h7E, 1);
        deselect();
        chk("two_byte_pulses", n_rxv - r0, 2);

        r0 = n_rxv;
        set_nss(0);
        wait_clk(6);
        for (int i = 0; i < 5; i++) bit_cycle(i[0], 0, 0);
        deselect();
        chk("partial_no_rx", n_rxv - r0, 0);
        set_nss(0);
        wait_clk(6);
        xfer_byte(8'hC3, 8'h00, 0);
        deselect();
        chk("after_partial_pulses", n_rxv - r0, 1);

        r0 = n_rxv;
        set_nss(0);
        wait_clk(6);
        for (int i = 0; i < 3; i++) bit_cycle(1, 0, 0);
        sck = 1;
        wait_clk(3);
        rst = 1;
        wait_clk(3);
        sck = 0;
        wait_clk(2);
        check_reset_outputs("midreset");
        rst = 0;
        for (int i = 0; i < 10; i++) bit_cycle(i[1], 0, 0);
        chk("post_reset_no_rx", n_rxv - r0, 0);
        chk("post_reset_busy", {31'd0, m_busy}, 32'd0);
        chk("post_reset_oe", {31'd0, m_oe}, 32'd0);
        set_nss(1);
        wait_clk(6);
        write_tx(8'h11);
        set_nss(0);
        wait_clk(6);
        xfer_byte(8'h3E, 8'h11, 1);
        deselect();
        chk("post_reset_frame_pulses", n_rxv - r0, 1);

        sel = 1;
        wait_clk(2);
        r0 = n_rxv;
        u0 = n_und;
        tx_data = 8'hF0;
        set_nss(0);
        wait_clk(2);
        tx_valid1 = 1;
        wait_clk(1);
        tx_valid1 = 0;
        wait_clk(4);
        chk("cpol1_bypass_no_und", n_und - u0, 0);
        chk("cpol1_ready_after_bypass", {31'd0, m_rdy}, 32'd1);
        chk("cpol1_busy", {31'd0, m_busy}, 32'd1);
        xfer_byte(8'h5A, 8'hF0, 1);
        deselect();
        chk("cpol1_rx_pulses", n_rxv - r0, 1);
        chk("cpol1_rxd", {24'd0, m_rxd}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
